// File: rtl/coin_acceptor.sv
// Coin-sensor front end: 2-flop sync, debounce, ambiguity/busy rejection, one-cycle coin pulses.
// Optional audit counters are enabled by defining COIN_ACCEPTOR_AUDIT_EN.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_n,
    input  logic       sens_d,
    input  logic       sens_q,
    input  logic       busy,
    output logic       nickle,
    output logic       dime,
    output logic       quarter,
    output logic       reject,
    output logic [7:0] coin_cnt,
    output logic [7:0] rej_cnt
);
    typedef enum logic [2:0] {IDLE, QUAL, EMIT, REJ, REL} state_t;

    localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] kind;
    logic [2:0] s1, s2;
    logic [2:0] v;
    logic       onehot;

    assign v      = s2;
    assign onehot = (v != 3'd0) && ((v & (v - 3'd1)) == 3'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            kind    <= 3'd0;
            s1      <= 3'd0;
            s2      <= 3'd0;
            nickle  <= 1'b0;
            dime    <= 1'b0;
            quarter <= 1'b0;
            reject  <= 1'b0;
        end else begin
            s1      <= {sens_q, sens_d, sens_n};
            s2      <= s1;
            nickle  <= 1'b0;
            dime    <= 1'b0;
            quarter <= 1'b0;
            reject  <= 1'b0;
            case (state)
                IDLE: begin
                    if (onehot) begin
                        kind  <= v;
                        cnt   <= 4'd1;
                        state <= QUAL;
                    end else if (v != 3'd0) begin
                        reject <= 1'b1;
                        state  <= REJ;
                    end
                end
                QUAL: begin
                    if (v == kind) begin
                        if (cnt == LAST) begin
                            // busy only matters on this edge; the pulse is decoded here so it is registered
                            if (busy) reject <= 1'b1;
                            else {quarter, dime, nickle} <= kind;
                            state <= EMIT;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else if (v == 3'd0) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else begin
                        reject <= 1'b1;
                        state  <= REJ;
                    end
                end
                EMIT, REJ: begin
                    cnt   <= 4'd0;
                    state <= REL;
                end
                REL: begin
                    // wait for a clean release; anything seen meanwhile is swallowed silently
                    if (v != 3'd0) begin
                        cnt <= 4'd0;
                    end else if (cnt == LAST) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    cnt   <= 4'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef COIN_ACCEPTOR_AUDIT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            coin_cnt <= 8'd0;
            rej_cnt  <= 8'd0;
        end else begin
            if ((nickle || dime || quarter) && coin_cnt != 8'hFF) coin_cnt <= coin_cnt + 8'd1;
            if (reject && rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
        end
    end
`else
    assign coin_cnt = 8'd0;
    assign rej_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: pulse timing, glitch/ambiguity/busy rejection, reset, audit saturation.
module tb_coin_acceptor;
    logic       clk = 1'b0;
    logic       reset, sens_n, sens_d, sens_q, busy;
    logic       nickle, dime, quarter, reject;
    logic [7:0] coin_cnt, rej_cnt;

    int total = 0;
    int bad   = 0;
    int n_seen = 0, d_seen = 0, q_seen = 0, r_seen = 0, excl_bad = 0;
    int exp_coin = 0, exp_rej = 0;
    int b_n, b_d, b_q, b_r;

    coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .sens_n(sens_n), .sens_d(sens_d), .sens_q(sens_q),
        .busy(busy), .nickle(nickle), .dime(dime), .quarter(quarter), .reject(reject),
        .coin_cnt(coin_cnt), .rej_cnt(rej_cnt)
    );

    always #5 clk = ~clk;

    // pulse monitor samples just after each rising edge
    always @(posedge clk) begin
        #1;
        if (nickle)  n_seen++;
        if (dime)    d_seen++;
        if (quarter) q_seen++;
        if (reject)  r_seen++;
        if ((int'(nickle) + int'(dime) + int'(quarter) + int'(reject)) > 1) excl_bad++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_n = n_seen; b_d = d_seen; b_q = q_seen; b_r = r_seen;
    endtask

    task automatic add_coin();
`ifdef COIN_ACCEPTOR_AUDIT_EN
        if (exp_coin < 255) exp_coin++;
`endif
    endtask

    task automatic add_rej();
`ifdef COIN_ACCEPTOR_AUDIT_EN
        if (exp_rej < 255) exp_rej++;
`endif
    endtask

    initial begin
        reset = 1'b0; sens_n = 1'b0; sens_d = 1'b0; sens_q = 1'b0; busy = 1'b0;
        step(2);
        chk("rst_outs", {nickle, dime, quarter, reject}, 0);
        chk("rst_coin_cnt", coin_cnt, 0);
        chk("rst_rej_cnt", rej_cnt, 0);
        reset = 1'b1;
        step(2);

        // quarter held 10 cycles
        snap();
        sens_q = 1'b1;
        step(5);  chk("q_early", quarter, 0);
        step(1);  chk("q_pulse", quarter, 1);
        chk("q_others", {nickle, dime, reject}, 0);
        step(1);  chk("q_fall", quarter, 0);
        step(3);  sens_q = 1'b0;
        step(8);
        add_coin();
        chk("q_count", q_seen - b_q, 1);
        chk("q_nonq", (n_seen - b_n) + (d_seen - b_d) + (r_seen - b_r), 0);
        chk("q_coin_cnt", coin_cnt, exp_coin);

        // nickel with a one-sample dropout restarting qualification
        snap();
        sens_n = 1'b1; step(2);
        sens_n = 1'b0; step(1);
        sens_n = 1'b1;
        step(5);  chk("n_early", nickle, 0);
        step(1);  chk("n_pulse", nickle, 1);
        step(4);  sens_n = 1'b0;
        step(8);
        add_coin();
        chk("n_count", n_seen - b_n, 1);
        chk("n_rej", r_seen - b_r, 0);
        chk("n_rej_cnt", rej_cnt, exp_rej);

        // dime+quarter together -> reject, then a clean dime
        snap();
        sens_d = 1'b1; sens_q = 1'b1;
        step(2);  chk("dq_early", reject, 0);
        step(1);  chk("dq_reject", reject, 1);
        step(1);  chk("dq_fall", reject, 0);
        step(16);
        sens_d = 1'b0; sens_q = 1'b0;
        step(4);
        sens_d = 1'b1;
        step(5);  chk("d_early", dime, 0);
        step(1);  chk("d_pulse", dime, 1);
        step(4);  sens_d = 1'b0;
        step(8);
        add_rej(); add_coin();
        chk("dq_rej_count", r_seen - b_r, 1);
        chk("dq_dime_count", d_seen - b_d, 1);
        chk("dq_q_count", q_seen - b_q, 0);

        // dime while busy -> reject instead
        snap();
        busy = 1'b1; sens_d = 1'b1;
        step(5);  chk("busy_early", reject, 0);
        step(1);  chk("busy_reject", reject, 1);
        chk("busy_nodime", dime, 0);
        step(4);  sens_d = 1'b0;
        step(8);  busy = 1'b0;
        add_rej();
        chk("busy_dime_count", d_seen - b_d, 0);
        chk("busy_coin_cnt", coin_cnt, exp_coin);
        chk("busy_rej_cnt", rej_cnt, exp_rej);

        // reset mid-qualification, sensor still held
        snap();
        sens_n = 1'b1;
        step(3);
        reset = 1'b0;
        step(1);
        chk("mid_rst_outs", {nickle, dime, quarter, reject}, 0);
        chk("mid_rst_cnts", {coin_cnt, rej_cnt}, 0);
        exp_coin = 0; exp_rej = 0;
        reset = 1'b1;
        step(5);  chk("rr_early", nickle, 0);
        step(1);  chk("rr_pulse", nickle, 1);
        step(4);  sens_n = 1'b0;
        step(8);
        add_coin();
        chk("rr_count", n_seen - b_n, 1);

        // 256 quarters: audit counter saturates
        snap();
        for (int i = 0; i < 256; i++) begin
            sens_q = 1'b1; step(6);
            sens_q = 1'b0; step(8);
            add_coin();
        end
        chk("sat_q_count", q_seen - b_q, 256);
        chk("sat_coin_cnt", coin_cnt, exp_coin);
        chk("sat_rej_cnt", rej_cnt, exp_rej);
        chk("exclusive", excl_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
